// File: rtl/game_pkg.sv
// Shared types and widths for the game flow sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_SPAWN = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_DEATH = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6,
    S_WIN   = 3'd7
  } game_state_t;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 4;

  // States whose exit is timed by the frame delay counter.
  function automatic logic is_delay_state(input game_state_t s);
    return (s == S_SPAWN) || (s == S_DEATH) || (s == S_CLEAR);
  endfunction

endpackage

// File: rtl/frame_delay.sv
// Frame-tick pause counter: counts ticks since clr, flags the DELAY_FRAMES-th tick.
module frame_delay #(
  parameter int DELAY_FRAMES = 90
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic done
);

  localparam int CNT_W = $clog2(DELAY_FRAMES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = tick && (cnt_q == CNT_W'(DELAY_FRAMES - 1));

  // clr has priority so the timeout tick that causes a state change restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: title/spawn/play/pause/death/clear/over/win, owning lives and level.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int NUM_LEVELS   = 4,
  parameter int DELAY_FRAMES = 90
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               player_hit,
  input  logic               wave_cleared,
  input  logic               invaders_landed,
  output logic               play_en,
  output logic               wave_load,
  output logic               player_respawn,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output game_state_t        state,
  output logic               game_lost,
  output logic               game_won
);

  game_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               wave_load_q, wave_load_d;
  logic               player_respawn_q, player_respawn_d;
  logic               play_en_q, play_en_d;
  logic               game_lost_q, game_lost_d;
  logic               game_won_q, game_won_d;

  logic delay_clr, delay_tick, delay_done;

  assign delay_tick = frame_tick && is_delay_state(state_q);
  assign delay_clr  = (state_d != state_q);

  frame_delay #(
    .DELAY_FRAMES(DELAY_FRAMES)
  ) u_frame_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (delay_clr),
    .tick (delay_tick),
    .done (delay_done)
  );

  always_comb begin
    state_d          = state_q;
    lives_d          = lives_q;
    level_d          = level_q;
    wave_load_d      = 1'b0;
    player_respawn_d = 1'b0;
    case (state_q)
      S_TITLE: begin
        if (start_btn) begin
          state_d          = S_SPAWN;
          lives_d          = LIVES_W'(LIVES_INIT);
          level_d          = '0;
          wave_load_d      = 1'b1;
          player_respawn_d = 1'b1;
        end
      end
      S_SPAWN: begin
        if (delay_done) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (invaders_landed) begin
          state_d = S_OVER;
          lives_d = '0;
        end else if (player_hit) begin
          // lives<=1 also covers a zero count so the counter can never wrap.
          if (lives_q <= LIVES_W'(1)) begin
            state_d = S_OVER;
            lives_d = '0;
          end else begin
            state_d = S_DEATH;
            lives_d = lives_q - LIVES_W'(1);
          end
        end else if (wave_cleared) begin
          state_d = (level_q == LEVEL_W'(NUM_LEVELS - 1)) ? S_WIN : S_CLEAR;
        end else if (pause_btn) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_btn) begin
          state_d = S_PLAY;
        end else if (start_btn) begin
          state_d = S_TITLE;
        end
      end
      S_DEATH: begin
        if (delay_done) begin
          state_d          = S_SPAWN;
          player_respawn_d = 1'b1;
        end
      end
      S_CLEAR: begin
        if (delay_done) begin
          state_d          = S_SPAWN;
          wave_load_d      = 1'b1;
          player_respawn_d = 1'b1;
          if (level_q != LEVEL_W'(NUM_LEVELS - 1)) level_d = level_q + LEVEL_W'(1);
        end
      end
      S_OVER, S_WIN: begin
        if (start_btn) state_d = S_TITLE;
      end
      default: state_d = S_TITLE;
    endcase
    play_en_d   = (state_d == S_PLAY);
    game_lost_d = (state_d == S_OVER);
    game_won_d  = (state_d == S_WIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_TITLE;
      lives_q          <= LIVES_W'(LIVES_INIT);
      level_q          <= '0;
      wave_load_q      <= 1'b0;
      player_respawn_q <= 1'b0;
      play_en_q        <= 1'b0;
      game_lost_q      <= 1'b0;
      game_won_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      lives_q          <= lives_d;
      level_q          <= level_d;
      wave_load_q      <= wave_load_d;
      player_respawn_q <= player_respawn_d;
      play_en_q        <= play_en_d;
      game_lost_q      <= game_lost_d;
      game_won_q       <= game_won_d;
    end
  end

  assign state          = state_q;
  assign lives          = lives_q;
  assign level          = level_q;
  assign wave_load      = wave_load_q;
  assign player_respawn = player_respawn_q;
  assign play_en        = play_en_q;
  assign game_lost      = game_lost_q;
  assign game_won       = game_won_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: vector table, hand sequences, and random play against a reference model.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int LIVES_INIT   = 3;
  localparam int NUM_LEVELS   = 4;
  localparam int DELAY_FRAMES = 90;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        pause_btn = 1'b0;
  logic        player_hit = 1'b0;
  logic        wave_cleared = 1'b0;
  logic        invaders_landed = 1'b0;
  logic        play_en, wave_load, player_respawn, game_lost, game_won;
  logic [2:0]  lives;
  logic [3:0]  level;
  game_state_t state;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  game_flow_ctrl #(
    .LIVES_INIT  (LIVES_INIT),
    .NUM_LEVELS  (NUM_LEVELS),
    .DELAY_FRAMES(DELAY_FRAMES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .start_btn      (start_btn),
    .pause_btn      (pause_btn),
    .player_hit     (player_hit),
    .wave_cleared   (wave_cleared),
    .invaders_landed(invaders_landed),
    .play_en        (play_en),
    .wave_load      (wave_load),
    .player_respawn (player_respawn),
    .lives          (lives),
    .level          (level),
    .state          (state),
    .game_lost      (game_lost),
    .game_won       (game_won)
  );

  // ---------------- reference model ----------------
  // Tracks the phase and the number of frames still to wait before the pause ends.
  game_state_t m_st;
  int          m_lives, m_level, m_frames_left;
  logic        m_wl, m_rs;

  task automatic model_reset();
    m_st = S_TITLE; m_lives = LIVES_INIT; m_level = 0; m_frames_left = DELAY_FRAMES;
    m_wl = 1'b0; m_rs = 1'b0;
  endtask

  task automatic model_step(input logic s, p, h, c, l, t);
    m_wl = 1'b0; m_rs = 1'b0;
    case (m_st)
      S_TITLE: if (s) begin
        m_st = S_SPAWN; m_lives = LIVES_INIT; m_level = 0;
        m_wl = 1'b1; m_rs = 1'b1; m_frames_left = DELAY_FRAMES;
      end
      S_SPAWN, S_DEATH, S_CLEAR: if (t) begin
        m_frames_left = m_frames_left - 1;
        if (m_frames_left == 0) begin
          m_frames_left = DELAY_FRAMES;
          if (m_st == S_SPAWN) m_st = S_PLAY;
          else begin
            m_rs = 1'b1;
            if (m_st == S_CLEAR) begin
              m_wl = 1'b1;
              if (m_level < NUM_LEVELS - 1) m_level = m_level + 1;
            end
            m_st = S_SPAWN;
          end
        end
      end
      S_PLAY: begin
        if (l) begin
          m_st = S_OVER; m_lives = 0;
        end else if (h) begin
          if (m_lives <= 1) begin m_st = S_OVER; m_lives = 0; end
          else begin m_st = S_DEATH; m_lives = m_lives - 1; m_frames_left = DELAY_FRAMES; end
        end else if (c) begin
          if (m_level == NUM_LEVELS - 1) m_st = S_WIN;
          else begin m_st = S_CLEAR; m_frames_left = DELAY_FRAMES; end
        end else if (p) m_st = S_PAUSE;
      end
      S_PAUSE: begin
        if (p) m_st = S_PLAY;
        else if (s) m_st = S_TITLE;
      end
      default: if (s) m_st = S_TITLE;
    endcase
  endtask

  function automatic logic [14:0] model_vec();
    return {m_st, 3'(m_lives), 4'(m_level), (m_st == S_PLAY), m_wl, m_rs,
            (m_st == S_OVER), (m_st == S_WIN)};
  endfunction

  function automatic logic [14:0] exp_vec(input game_state_t st, input int lv, input int lev,
                                          input logic wl, input logic rs);
    return {st, 3'(lv), 4'(lev), (st == S_PLAY), wl, rs, (st == S_OVER), (st == S_WIN)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {state, lives, level, play_en, wave_load, player_respawn, game_lost, game_won};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got st=%0d lives=%0d lvl=%0d flags=%b, expected st=%0d lives=%0d lvl=%0d flags=%b",
                  name, act[14:12], act[11:9], act[8:5], act[4:0],
                  exp[14:12], exp[11:9], exp[8:5], exp[4:0]);
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input logic s, p, h, c, l, t);
    @(negedge clk);
    start_btn = s; pause_btn = p; player_hit = h;
    wave_cleared = c; invaders_landed = l; frame_tick = t;
    @(posedge clk);
    model_step(s, p, h, c, l, t);
    #1;
    check("cycle_vs_model", dut_vec(), model_vec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start_btn = 0; pause_btn = 0; player_hit = 0; wave_cleared = 0;
    invaders_landed = 0; frame_tick = 0;
    #1;
    model_reset();
    check("reset_state", dut_vec(), exp_vec(S_TITLE, LIVES_INIT, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic s, p, h, c, l, t;
    int n;
    game_state_t st;
    int lives, level;
    logic wl, rs;
    string name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic s, p, h, c, l, t, input int n,
                     input game_state_t st, input int lv, lev, input logic wl, rs);
    vec_t v;
    v.s = s; v.p = p; v.h = h; v.c = c; v.l = l; v.t = t; v.n = n;
    v.st = st; v.lives = lv; v.level = lev; v.wl = wl; v.rs = rs; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    //   name              s p h c l t   n    state    lv lev wl rs
    add("start_pulse",     1,0,0,0,0,0,   1, S_SPAWN,  3, 0, 1, 1);
    add("spawn_hold_89",   0,0,0,0,0,1,  89, S_SPAWN,  3, 0, 0, 0);
    add("spawn_to_play",   0,0,0,0,0,1,   1, S_PLAY,   3, 0, 0, 0);
    add("hit_beats_clear", 0,0,1,1,0,0,   1, S_DEATH,  2, 0, 0, 0);
    add("death_respawn",   0,0,0,0,0,1,  90, S_SPAWN,  2, 0, 0, 1);
    add("respawn_play",    0,0,0,0,0,1,  90, S_PLAY,   2, 0, 0, 0);
    add("wave_clear",      0,0,0,1,0,0,   1, S_CLEAR,  2, 0, 0, 0);
    add("clear_reload",    0,0,0,0,0,1,  90, S_SPAWN,  2, 1, 1, 1);
    add("level1_play",     0,0,0,0,0,1,  90, S_PLAY,   2, 1, 0, 0);
    add("pause_enter",     0,1,0,0,0,0,   1, S_PAUSE,  2, 1, 0, 0);
    add("pause_frozen",    0,0,0,0,0,1, 200, S_PAUSE,  2, 1, 0, 0);
    add("pause_exit",      0,1,0,0,0,0,   1, S_PLAY,   2, 1, 0, 0);
    add("hit_to_1",        0,0,1,0,0,0,   1, S_DEATH,  1, 1, 0, 0);
    add("respawn_again",   0,0,0,0,0,1,  90, S_SPAWN,  1, 1, 0, 1);
    add("play_lives1",     0,0,0,0,0,1,  90, S_PLAY,   1, 1, 0, 0);
    add("last_hit_over",   0,0,1,0,0,0,   1, S_OVER,   0, 1, 0, 0);
    add("over_no_respawn", 0,0,0,0,0,1,   5, S_OVER,   0, 1, 0, 0);
    add("over_pause_ign",  0,1,0,0,0,0,   1, S_OVER,   0, 1, 0, 0);
    add("over_to_title",   1,0,0,0,0,0,   1, S_TITLE,  0, 1, 0, 0);
    add("restart",         1,0,0,0,0,0,   1, S_SPAWN,  3, 0, 1, 1);
  end

  // ---------------- main test ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    foreach (tbl[k]) begin
      for (int i = 0; i < tbl[k].n; i++)
        cyc(tbl[k].s, tbl[k].p, tbl[k].h, tbl[k].c, tbl[k].l, tbl[k].t);
      check(tbl[k].name, dut_vec(),
            exp_vec(tbl[k].st, tbl[k].lives, tbl[k].level, tbl[k].wl, tbl[k].rs));
    end

    // Clear every wave until the win screen.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    ticks(DELAY_FRAMES);
    for (int lv = 0; lv < NUM_LEVELS - 1; lv++) begin
      cyc(0, 0, 0, 1, 0, 0);
      check("clear_enter", dut_vec(), exp_vec(S_CLEAR, 3, lv, 0, 0));
      ticks(DELAY_FRAMES);
      check("clear_wave_load", dut_vec(), exp_vec(S_SPAWN, 3, lv + 1, 1, 1));
      ticks(DELAY_FRAMES);
    end
    cyc(0, 0, 0, 1, 0, 0);
    check("last_wave_win", dut_vec(), exp_vec(S_WIN, 3, NUM_LEVELS - 1, 0, 0));
    ticks(3);
    cyc(1, 0, 0, 0, 0, 0);
    check("win_to_title", dut_vec(), exp_vec(S_TITLE, 3, NUM_LEVELS - 1, 0, 0));

    // Reach lives=1, level=2, then reset while playing.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0); ticks(DELAY_FRAMES);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 0, 0, 0); ticks(2 * DELAY_FRAMES);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, 0, 0); ticks(2 * DELAY_FRAMES);
    end
    check("pre_reset_play", dut_vec(), exp_vec(S_PLAY, 1, 2, 0, 0));
    do_reset();

    // Landing ends the game regardless of lives; abort and double-press from pause.
    cyc(1, 0, 0, 0, 0, 0); ticks(DELAY_FRAMES);
    cyc(0, 0, 0, 0, 1, 0);
    check("landed_over", dut_vec(), exp_vec(S_OVER, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); ticks(DELAY_FRAMES);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("pause_wins_start", dut_vec(), exp_vec(S_PLAY, 3, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("pause_abort", dut_vec(), exp_vec(S_TITLE, 3, 0, 0, 0));

    // Random play checked every cycle against the model.
    do_reset();
    for (int i = 0; i < 15000; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 299) == 0, $urandom_range(0, 249) == 0,
          $urandom_range(0, 1999) == 0, $urandom_range(0, 1) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
